// File: rtl/word_cla.sv
// -----------------------------------------------------------------------------
// word_cla
//   Registered WIDTH-bit two-level carry-lookahead adder. The word is split
//   into 4-bit CLA slices; each slice expands its internal carries in
//   lookahead form and exports a group generate/propagate pair. A second-level
//   lookahead unit turns the group pairs and CIn into every slice carry-in,
//   so no carry ripples inside or between slices.
//
// Ports
//   clk      in   1      rising-edge clock for all registers
//   rst_n    in   1      synchronous active-low reset (clears all outputs)
//   A        in   WIDTH  first operand (unsigned or two's complement)
//   B        in   WIDTH  second operand
//   CIn      in   1      carry-in at bit 0
//   Sum      out  WIDTH  registered (A+B+CIn) mod 2^WIDTH
//   COut     out  1      registered carry-out of bit WIDTH-1
//   Overflow out  1      registered signed-overflow flag
//
// WIDTH must be a multiple of 4 and at least 4. Latency is one cycle,
// throughput one operation per cycle, no state between operations.
// -----------------------------------------------------------------------------
module word_cla #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIn,
  output logic [WIDTH-1:0] Sum,
  output logic             COut,
  output logic             Overflow
);

  localparam int NSLICE = WIDTH / 4;

  // Carries c1..c3 of one 4-bit slice, each written out in full lookahead
  // form so that no carry term depends on another computed carry.
  function automatic logic [2:0] cla4_carries(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       c0
  );
    logic c1;
    logic c2;
    logic c3;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return {c3, c2, c1};
  endfunction

  // Group generate of a 4-bit slice: the slice produces a carry-out on its own.
  function automatic logic cla4_group_gen(
    input logic [3:0] g,
    input logic [3:0] p
  );
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Group propagate of a 4-bit slice: an incoming carry passes straight through.
  function automatic logic cla4_group_prop(
    input logic [3:0] p
  );
    return &p;
  endfunction

  logic [WIDTH-1:0]  w_g;
  logic [WIDTH-1:0]  w_p;
  logic [WIDTH-1:0]  w_c;          // carry into each bit position
  logic [NSLICE-1:0] w_grp_g;
  logic [NSLICE-1:0] w_grp_p;
  logic [NSLICE:0]   w_slice_cin;  // [0]=CIn, [k]=carry into slice k, [NSLICE]=carry-out
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic              w_ovf;

  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  assign w_g = A & B;
  assign w_p = A ^ B;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    assign w_c[4*s]         = w_slice_cin[s];
    assign w_c[4*s+1 +: 3]  = cla4_carries(w_g[4*s +: 4], w_p[4*s +: 4], w_slice_cin[s]);
    assign w_grp_g[s]       = cla4_group_gen(w_g[4*s +: 4], w_p[4*s +: 4]);
    assign w_grp_p[s]       = cla4_group_prop(w_p[4*s +: 4]);
  end

  // Second-level lookahead: every slice carry-in is built independently as
  // G[k] | P[k]G[k-1] | ... | P[k]..P[0]CIn from group pairs, never from a
  // neighbouring slice's computed carry.
  always_comb begin
    logic v_term;
    logic v_acc;
    v_term         = 1'b0;
    v_acc          = 1'b0;
    w_slice_cin    = '0;
    w_slice_cin[0] = CIn;
    for (int k = 0; k < NSLICE; k++) begin
      v_term = 1'b1;
      v_acc  = 1'b0;
      for (int j = k; j >= 0; j--) begin
        v_acc  = v_acc | (v_term & w_grp_g[j]);
        v_term = v_term & w_grp_p[j];
      end
      w_slice_cin[k+1] = v_acc | (v_term & CIn);
    end
  end

  assign w_sum  = w_p ^ w_c;
  assign w_cout = w_slice_cin[NSLICE];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign w_ovf  = w_c[WIDTH-1] ^ w_cout;

  // Result register with synchronous active-low clear; in-flight data is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign Sum      = r_sum;
  assign COut     = r_cout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_word_cla.sv
// -----------------------------------------------------------------------------
// tb_word_cla
//   Scoreboard bench for word_cla at WIDTH=16 and WIDTH=4. The driver pushes
//   the expected response, tagged with the clock edge that must produce it,
//   into a queue; a separate monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_word_cla;

  typedef struct {
    int          tgt;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        ci16;
  logic [15:0] sum16;
  logic        cout16;
  logic        ovf16;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        ci4;
  logic [3:0]  sum4;
  logic        cout4;
  logic        ovf4;

  int   cyc;
  int   tests;
  int   fails;
  exp_t q16[$];
  exp_t q4[$];

  word_cla #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .CIn(ci16),
    .Sum(sum16), .COut(cout16), .Overflow(ovf16)
  );

  word_cla #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .CIn(ci4),
    .Sum(sum4), .COut(cout4), .Overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic, deliberately plain wide addition plus the sign rule.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return {o, t};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    o = (a[3] == b[3]) && (t[3] != a[3]);
    return {o, t};
  endfunction

  task automatic step16(input logic r, input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    a16   = a;
    b16   = b;
    ci16  = ci;
    e.tgt = cyc + 1;
    e.s   = es;
    e.c   = ec;
    e.o   = eo;
    q16.push_back(e);
  endtask

  task automatic step4(input logic r, input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] es, input logic ec, input logic eo);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    a4    = a;
    b4    = b;
    ci4   = ci;
    e.tgt = cyc + 1;
    e.s   = {12'd0, es};
    e.c   = ec;
    e.o   = eo;
    q4.push_back(e);
  endtask

  // Monitor: compare every expectation due at the edge just passed.
  always @(negedge clk) begin
    exp_t e;
    while (q16.size() > 0 && q16[0].tgt <= cyc) begin
      e = q16.pop_front();
      tests++;
      if (e.tgt != cyc || sum16 !== e.s || cout16 !== e.c || ovf16 !== e.o) begin
        fails++;
        $display("FAIL w16 edge %0d (due %0d): got Sum=%h COut=%b Ovf=%b, want Sum=%h COut=%b Ovf=%b",
                 cyc, e.tgt, sum16, cout16, ovf16, e.s, e.c, e.o);
      end
    end
    while (q4.size() > 0 && q4[0].tgt <= cyc) begin
      e = q4.pop_front();
      tests++;
      if (e.tgt != cyc || {12'd0, sum4} !== e.s || cout4 !== e.c || ovf4 !== e.o) begin
        fails++;
        $display("FAIL w4 edge %0d (due %0d): got Sum=%h COut=%b Ovf=%b, want Sum=%h COut=%b Ovf=%b",
                 cyc, e.tgt, sum4, cout4, ovf4, e.s[3:0], e.c, e.o);
      end
    end
  end

  initial begin
    logic [17:0] m16;
    logic [5:0]  m4;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    int          wait_cnt;
    cyc   = 0;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
    a4  = 4'hF;     b4  = 4'hF;     ci4  = 1'b1;

    // Reset with all-ones inputs on both instances.
    step4 (1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
    step16(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Directed WIDTH=16 vectors, back to back.
    step16(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    step16(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    step16(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    step16(1'b1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    step16(1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    step16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step16(1'b1, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    step16(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    step16(1'b1, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    step16(1'b1, 16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0);
    // Reset mid-stream discards the in-flight sum; first edge after release adds.
    step16(1'b0, 16'h1234, 16'h4321, 1'b1, 16'h0000, 1'b0, 1'b0);
    step16(1'b1, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Random back-to-back WIDTH=16 with a reset pulse in the middle.
    for (int i = 0; i < 120; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 60) begin
        step16(1'b0, ra, rb, rc, 16'h0000, 1'b0, 1'b0);
      end else begin
        m16 = model16(ra, rb, rc);
        step16(1'b1, ra, rb, rc, m16[15:0], m16[16], m16[17]);
      end
    end

    // Random back-to-back WIDTH=4 with a reset pulse; start with a reset edge.
    step4(1'b0, 4'h7, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
    step4(1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    step4(1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
    step4(1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    step4(1'b1, 4'h7, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1);
    for (int i = 0; i < 120; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 50) begin
        step4(1'b0, ra[3:0], rb[3:0], rc, 4'h0, 1'b0, 1'b0);
      end else begin
        m4 = model4(ra[3:0], rb[3:0], rc);
        step4(1'b1, ra[3:0], rb[3:0], rc, m4[3:0], m4[4], m4[5]);
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    wait_cnt = 0;
    while ((q16.size() > 0 || q4.size() > 0) && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    #1;
    if (q16.size() > 0 || q4.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d/%0d expectations left, want 0", q16.size(), q4.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_cla.md
WORD_CLA -- requirements
Module: word_cla

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the operand width; legal values are multiples of 4 that are at least 4, and WIDTH=4 gives the four-bit slice behaviour.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 A  input  WIDTH  first operand, two's-complement or unsigned.
REQ-006 B  input  WIDTH  second operand.
REQ-007 CIn  input  1  carry-in, added at bit 0.
REQ-008 Sum  output  WIDTH  registered sum, equal to (A+B+CIn) mod 2^WIDTH.
REQ-009 COut  output  1  registered carry-out from bit WIDTH-1.
REQ-010 Overflow  output  1  registered signed-overflow flag.

Function
REQ-011 The adder core SHALL be a carry-lookahead structure built from 4-bit CLA slices.
- Each slice: bitwise generate g=A&B, propagate p=A^B, carries c[i+1]=g[i]|p[i]&c[i] expanded in lookahead form (no ripple inside a slice).
- Each slice exports group generate G and group propagate P.
REQ-012 Slice carry-ins SHALL come from a second-level lookahead unit that uses group G/P and CIn; ripple between slices is not allowed.
REQ-013 The sum bits SHALL be p[i]^c[i].
REQ-014 {COut,Sum} SHALL equal A+B+CIn as a WIDTH+1-bit unsigned result for every input combination.
REQ-015 Overflow SHALL be 1 exactly when A[WIDTH-1]==B[WIDTH-1] and Sum[WIDTH-1]!=A[WIDTH-1].
- This is equivalent to carry into the MSB XOR COut.
- CIn is included in this evaluation.
REQ-016 Sum, COut and Overflow SHALL be registered on the rising clk edge.
- Latency: exactly 1 cycle from the inputs being present before an edge to the result appearing after that edge.
REQ-017 There SHALL be no handshake.
- New operands are accepted every cycle (throughput 1 per cycle).
- Outputs hold between edges.
REQ-018 Outputs SHALL be functions of the current sampled inputs only; no state is carried between operations.
REQ-019 Wrap-around SHALL be modulo 2^WIDTH, with the carry reported on COut; overflow is flagged but never saturated.

Reset
REQ-020 When rst_n=0 at a rising clk edge, Sum, COut and Overflow SHALL all become 0 on that edge.
- A,B and CIn are ignored while rst_n=0.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; the outputs are 0 after that edge.
REQ-022 After rst_n returns to 1, the first edge SHALL register the result of the then-present inputs.
REQ-023 The outputs SHALL be undefined before the first reset edge; the bench applies reset first.

Verification (WIDTH=16; each response is checked one edge after the stimulus)
REQ-024 Reset: rst_n=0 with A=0xFFFF, B=0xFFFF, CIn=1 -> Sum=0x0000, COut=0, Overflow=0.
REQ-025 Positive overflow and negative overflow:
- A=0x7FFF, B=0x0001, CIn=0 -> Sum=0x8000, COut=0, Overflow=1.
- A=0x8000, B=0x8000, CIn=0 -> Sum=0x0000, COut=1, Overflow=1.
REQ-026 Unsigned wrap without signed overflow: A=0xFFFF, B=0x0001, CIn=0 -> Sum=0x0000, COut=1, Overflow=0.
REQ-027 Carry-in cases:
- A=0x7FFF, B=0x0000, CIn=1 -> Sum=0x8000, Overflow=1.
- A=0x1234, B=0x4321, CIn=1 -> Sum=0x5556, COut=0, Overflow=0.
REQ-028 Randomized back-to-back run:
- At least 100 random {CIn,B,A} vectors, one per cycle, plus a mid-run reset pulse.
- Each {COut,Sum} matches A+B+CIn.
- Each Overflow matches REQ-015.
- Repeat the run with WIDTH=4.
